// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: state encodings, pointer reset value and ring helpers shared by rr_arbiter4 and rr_pointer4.
package rr_arbiter4_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam logic [3:0] PTR_RST = 4'b1000;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    // Ring position of a one-hot line: bit 3 is position 0, bit 0 is position 3.
    function automatic logic [1:0] ring_pos(input logic [3:0] v);
        return v[3] ? 2'd0 : v[2] ? 2'd1 : v[1] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/rr_pointer4.sv
// rr_pointer4: one-hot rotating priority pointer and wrap-around winner scan for a 4-line ring.
module rr_pointer4 import rr_arbiter4_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] req,
    output logic [3:0] winner,
    output logic [1:0] winner_id
);

    logic [3:0] ptr;
    logic [1:0] start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= PTR_RST;
        else if (load && |winner)
            ptr <= {winner[0], winner[3:1]};
    end

    assign start = ~ring_pos(ptr);

    // Scan from the pointer bit downward; the nearest asserted bit is written last and wins.
    always_comb begin
        winner = '0;
        for (int k = 3; k >= 0; k--)
            if (req[start - 2'(k)])
                winner = 4'b0001 << (start - 2'(k));
    end

    assign winner_id = |winner ? ring_pos(winner) : 2'd0;

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-line round-robin arbiter with IDLE/GRANT/RELEASE FSM and registered outputs.
// Define RR_ARBITER4_TIMEOUT_EN to revoke grants held for TIMEOUT_CYCLES cycles.
module rr_arbiter4 import rr_arbiter4_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    state_t     state, state_n;
    logic [3:0] winner, gnt_n;
    logic [1:0] winner_id, gnt_id_n;
    logic       load, hold;

    assign hold = |(req & gnt);

    rr_pointer4 u_ptr (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .req       (req),
        .winner    (winner),
        .winner_id (winner_id)
    );

`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] hold_cnt, hold_cnt_n;
    logic       timeout_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_n;
            timeout  <= timeout_n;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_n  = IDLE;
        gnt_n    = '0;
        gnt_id_n = '0;
        load     = 1'b0;
`ifdef RR_ARBITER4_TIMEOUT_EN
        hold_cnt_n = '0;
        timeout_n  = 1'b0;
`endif
        case (state)
            IDLE: if (|req) begin
                state_n  = GRANT;
                gnt_n    = winner;
                gnt_id_n = winner_id;
                load     = 1'b1;
            end
            // A dropped request wins over an expiring hold counter.
            GRANT: if (!hold)
                state_n = RELEASE;
`ifdef RR_ARBITER4_TIMEOUT_EN
            else if (hold_cnt == HOLD_LAST) begin
                state_n   = RELEASE;
                timeout_n = 1'b1;
            end
`endif
            else begin
                state_n  = GRANT;
                gnt_n    = gnt;
                gnt_id_n = gnt_id;
`ifdef RR_ARBITER4_TIMEOUT_EN
                hold_cnt_n = hold_cnt + 8'd1;
`endif
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            busy   <= state_n != IDLE;
        end
    end

endmodule
